// File: rtl/mux_pkg.sv
// Shared constants and helpers for the scanning channel multiplexer.
package mux_pkg;

  // Operating state encoding
  localparam logic [1:0] ST_MANUAL = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_PAUSE  = 2'd2;

  // Ceiling log2 for deriving index/counter widths; clog2(1) = 0
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Counts cycles spent on one channel; flags the last cycle of each dwell.
module dwell_timer #(
  parameter int unsigned DWELL = 100000000,
  parameter int unsigned CNT_W = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [CNT_W-1:0] cnt;

  // Pulses on the counting cycle that completes the dwell
  assign expire = enable && (cnt == CNT_W'(DWELL - 1));

  // Clear wins; otherwise count while enabled and wrap at the end of a dwell
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= expire ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mux_scan_nto1.sv
// Registered N:1 multiplexer with manual select, round-robin auto-scan,
// pause control and a channel-change strobe.
module mux_scan_nto1
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DWELL    = 100000000,
  localparam int unsigned SEL_W   = clog2(CHANNELS),
  localparam int unsigned CNT_W   = (clog2(DWELL) > 0) ? clog2(DWELL) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [SEL_W-1:0]          s,
  input  logic                      mode,
  input  logic                      hold,
  output logic [WIDTH-1:0]          x,
  output logic [SEL_W-1:0]          ch,
  output logic                      ch_stb
);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic             timer_clear;
  logic             timer_enable;
  logic             dwell_expire;
  logic             s_valid;
  logic [SEL_W-1:0] ch_wrap;
  logic [SEL_W-1:0] ch_next;
  logic [WIDTH-1:0] chan_data;

  dwell_timer #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expire (dwell_expire)
  );

  // Out-of-range selects are ignored; wider compare handles power-of-2 counts
  assign s_valid = (32'(s) < CHANNELS);
  assign ch_wrap = (ch == SEL_W'(CHANNELS - 1)) ? '0 : ch + SEL_W'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_MANUAL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state follows mode/hold directly, so a mode change overrides expiry
  always_comb begin
    state_d      = ST_MANUAL;
    timer_clear  = 1'b1;
    timer_enable = 1'b0;
    if (mode) begin
      state_d = hold ? ST_PAUSE : ST_SCAN;
    end
    case (state_d)
      ST_SCAN: begin
        timer_clear  = 1'b0;
        timer_enable = 1'b1;
      end
      // A pause entered straight from manual keeps a zero count
      ST_PAUSE: timer_clear = (state_q == ST_MANUAL);
      default:  timer_clear = 1'b1;
    endcase
  end

  // Channel chosen for the coming edge
  always_comb begin
    ch_next = ch;
    case (state_d)
      ST_SCAN:   if (dwell_expire) ch_next = ch_wrap;
      ST_PAUSE:  ch_next = ch;
      default:   if (s_valid) ch_next = s;
    endcase
  end

  assign chan_data = d[32'(ch_next) * WIDTH +: WIDTH];

  // Output registers: data re-sampled every cycle, strobe only on a channel change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch     <= '0;
      x      <= '0;
      ch_stb <= 1'b0;
    end else begin
      ch     <= ch_next;
      x      <= chan_data;
      ch_stb <= (ch_next != ch);
    end
  end

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Self-checking bench for mux_scan_nto1 (WIDTH=4, CHANNELS=5, DWELL=3).
module tb_mux_scan_nto1;

  localparam int unsigned W  = 4;
  localparam int unsigned NC = 5;
  localparam int unsigned DW = 3;
  localparam int unsigned SW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  data [NC];
  logic [NC*W-1:0] d;
  logic [SW-1:0] s;
  logic          mode;
  logic          hold;
  logic [W-1:0]  x;
  logic [SW-1:0] ch;
  logic          ch_stb;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: current channel, cycles already spent in the dwell
  int           m_ch;
  int           m_pos;
  logic [W-1:0] m_x;
  logic         m_stb;

  always #5 clk = ~clk;

  assign d = {data[4], data[3], data[2], data[1], data[0]};

  mux_scan_nto1 #(
    .WIDTH    (W),
    .CHANNELS (NC),
    .DWELL    (DW)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (d),
    .s      (s),
    .mode   (mode),
    .hold   (hold),
    .x      (x),
    .ch     (ch),
    .ch_stb (ch_stb)
  );

  task automatic model_reset();
    m_ch = 0; m_pos = 0; m_x = '0; m_stb = 1'b0;
  endtask

  // Advance one clock, update the model from the inputs seen at the edge, settle
  task automatic cycle();
    int prev;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      prev = m_ch;
      if (!mode) begin
        m_pos = 0;
        if (int'(s) < NC) m_ch = int'(s);
      end else if (!hold) begin
        m_pos = m_pos + 1;
        if (m_pos == DW) begin
          m_pos = 0;
          m_ch  = (m_ch + 1) % NC;
        end
      end
      m_x   = data[m_ch];
      m_stb = (m_ch != prev);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b0; hold = 1'b0; s = '0;
    for (int k = 0; k < NC; k++) data[k] = W'(k + 1);
    model_reset();
    @(posedge clk); #1;
    n_checks++;
    if (x !== 4'h0 || ch !== 3'd0 || ch_stb !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: x=%h ch=%0d stb=%b, required 0/0/0", x, ch, ch_stb);
    end
    rst_n = 1'b1;
    cycle();
    n_checks++;
    if (x !== 4'h1 || ch !== 3'd0 || ch_stb !== 1'b0) begin
      n_fail++;
      $display("FAIL after_release: x=%h ch=%0d stb=%b, required 1/0/0", x, ch, ch_stb);
    end
  endtask

  task automatic test_async_reset();
    s = 3'd3; mode = 1'b0; hold = 1'b0;
    cycle();
    mode = 1'b1;
    cycle();
    cycle();
    n_checks++;
    if (ch !== 3'd3 || x !== 4'h4) begin
      n_fail++;
      $display("FAIL pre_reset_scan: ch=%0d x=%h, required 3/4", ch, x);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (x !== 4'h0 || ch !== 3'd0 || ch_stb !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_immediate: x=%h ch=%0d stb=%b, required 0/0/0", x, ch, ch_stb);
    end
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if (x !== 4'h0 || ch !== 3'd0 || ch_stb !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_held_%0d: x=%h ch=%0d stb=%b, required 0/0/0", i, x, ch, ch_stb);
      end
    end
    mode = 1'b0; s = 3'd0;
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_manual();
    mode = 1'b0; hold = 1'b0; s = 3'd2;
    cycle();
    n_checks++;
    if (ch !== 3'd2 || x !== 4'h3 || ch_stb !== 1'b1) begin
      n_fail++;
      $display("FAIL manual_sel2: ch=%0d x=%h stb=%b, required 2/3/1", ch, x, ch_stb);
    end
    cycle();
    n_checks++;
    if (ch !== 3'd2 || x !== 4'h3 || ch_stb !== 1'b0) begin
      n_fail++;
      $display("FAIL manual_stb_one_cycle: ch=%0d x=%h stb=%b, required 2/3/0", ch, x, ch_stb);
    end
    for (int v = 5; v <= 7; v++) begin
      s = SW'(v);
      cycle();
      n_checks++;
      if (ch !== 3'd2 || x !== 4'h3 || ch_stb !== 1'b0) begin
        n_fail++;
        $display("FAIL manual_out_of_range_s%0d: ch=%0d x=%h stb=%b, required 2/3/0", v, ch, x, ch_stb);
      end
    end
  endtask

  task automatic test_scan_wrap();
    int exp_ch [9] = '{3, 3, 4, 4, 4, 0, 0, 0, 1};
    mode = 1'b0; s = 3'd3;
    cycle();
    cycle();
    mode = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cycle();
      n_checks++;
      if (ch !== SW'(exp_ch[i]) || x !== W'(exp_ch[i] + 1) ||
          ch_stb !== ((i == 2) || (i == 5) || (i == 8))) begin
        n_fail++;
        $display("FAIL scan_wrap_cycle%0d: ch=%0d x=%h stb=%b, required ch=%0d", i, ch, x, ch_stb, exp_ch[i]);
      end
    end
  endtask

  task automatic wait_advance(input string name);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!ch_stb && n < 12);
    if (!ch_stb) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no channel advance within 12 cycles", name);
    end
  endtask

  task automatic test_hold();
    int held;
    mode = 1'b1; hold = 1'b0;
    wait_advance("hold");
    cycle();
    hold = 1'b1;
    held = m_ch;
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_checks++;
      if (ch !== SW'(held) || ch_stb !== 1'b0 || x !== m_x) begin
        n_fail++;
        $display("FAIL hold_frozen_%0d: ch=%0d stb=%b, required ch=%0d stb=0", i, ch, ch_stb, held);
      end
    end
    hold = 1'b0;
    cycle();
    n_checks++;
    if (ch !== SW'(held) || ch_stb !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release_1: ch=%0d stb=%b, required ch=%0d stb=0", ch, ch_stb, held);
    end
    cycle();
    n_checks++;
    if (ch !== SW'((held + 1) % NC) || ch_stb !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release_2: ch=%0d stb=%b, required ch=%0d stb=1", ch, ch_stb, (held + 1) % NC);
    end
  endtask

  task automatic test_coincident();
    mode = 1'b1; hold = 1'b0;
    wait_advance("coincident");
    cycle();
    cycle();
    mode = 1'b0; s = 3'd1;
    cycle();
    n_checks++;
    if (ch !== 3'd1 || x !== 4'h2 || ch_stb !== m_stb) begin
      n_fail++;
      $display("FAIL mode_drop_on_expiry: ch=%0d x=%h stb=%b, required 1/2/%b", ch, x, ch_stb, m_stb);
    end
    mode = 1'b1;
    cycle();
    cycle();
    hold = 1'b1;
    cycle();
    n_checks++;
    if (ch !== 3'd1 || ch_stb !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_on_expiry: ch=%0d stb=%b, required 1/0", ch, ch_stb);
    end
    hold = 1'b0;
    cycle();
    n_checks++;
    if (ch !== 3'd2 || x !== 4'h3 || ch_stb !== 1'b1) begin
      n_fail++;
      $display("FAIL resume_after_expiry_hold: ch=%0d x=%h stb=%b, required 2/3/1", ch, x, ch_stb);
    end
  endtask

  task automatic test_data();
    mode = 1'b0; hold = 1'b0; s = 3'd0;
    cycle();
    cycle();
    data[0] = 4'hA;
    cycle();
    n_checks++;
    if (ch !== 3'd0 || x !== 4'hA || ch_stb !== 1'b0) begin
      n_fail++;
      $display("FAIL data_tracking: ch=%0d x=%h stb=%b, required 0/a/0", ch, x, ch_stb);
    end
    s = 3'd0;
    cycle();
    n_checks++;
    if (ch !== 3'd0 || x !== 4'hA || ch_stb !== 1'b0) begin
      n_fail++;
      $display("FAIL same_select_rewrite: ch=%0d x=%h stb=%b, required 0/a/0", ch, x, ch_stb);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      hold = ($urandom_range(0, 4) == 0);
      s    = SW'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) data[$urandom_range(0, NC - 1)] = W'($urandom);
      cycle();
      n_checks++;
      if (x !== m_x || ch !== SW'(m_ch) || ch_stb !== m_stb) begin
        n_fail++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_cycle%0d: x=%h ch=%0d stb=%b, required x=%h ch=%0d stb=%b",
                   i, x, ch, ch_stb, m_x, m_ch, m_stb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_manual();
    test_scan_wrap();
    test_hold();
    test_coincident();
    test_data();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
